// File: rtl/mastermind_solver.sv
// mastermind_solver: automatic Mastermind codebreaker.
// Presents 4-digit guesses ({d3,d2,d1,d0}, 3 bits per digit), takes black/white
// peg feedback and picks each new guess as the first code in enumeration order
// (base-NUM_COLORS counter, d0 least significant) consistent with every stored
// (guess, feedback) pair. One history entry is checked per SEARCH cycle.
// Ports:
//   MAX10_CLK1_50          clock, rising edge
//   reset                  synchronous active-high reset
//   start                  starts a game from IDLE / DONE_WIN / DONE_FAIL
//   guess, guess_valid     presented guess, held until feedback arrives
//   fb_valid, fb_black, fb_white  feedback strobe and peg counts
//   busy, solved, failed   status flags
//   guess_count            guesses scored this game
//   checks                 consistency checks this game (only with
//                          MASTERMIND_SOLVER_STATS_EN defined)
module mastermind_solver #(
  parameter int unsigned NUM_COLORS  = 6,
  parameter int unsigned MAX_GUESSES = 10
) (
  input  logic        MAX10_CLK1_50,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] guess,
  output logic        guess_valid,
  input  logic        fb_valid,
  input  logic [2:0]  fb_black,
  input  logic [2:0]  fb_white,
  output logic        busy,
  output logic        solved,
  output logic        failed,
`ifdef MASTERMIND_SOLVER_STATS_EN
  output logic [15:0] checks,
`endif
  output logic [3:0]  guess_count
);

  localparam int unsigned IW = $clog2(MAX_GUESSES);
  localparam int unsigned LW = $clog2(MAX_GUESSES + 1);

  typedef enum logic [2:0] {
    IDLE, SEARCH, PRESENT, DONE_WIN, DONE_FAIL
  } state_t;

  typedef struct packed {
    logic [11:0] g;
    logic [2:0]  b;
    logic [2:0]  w;
  } hist_t;

  state_t          r_state;
  logic [11:0]     r_cand;
  logic [LW-1:0]   r_hist_len;
  logic [IW-1:0]   r_hist_idx;
  hist_t           r_hist [MAX_GUESSES];

  logic [5:0]      w_score;
  logic            w_match;
  logic            w_last_idx;
  logic [12:0]     w_cand_next;
  logic [12:0]     w_guess_next;
  logic [3:0]      w_fb_sum;

  // Number of digits in code equal to col
  function automatic logic [2:0] count_col(input logic [11:0] code, input logic [2:0] col);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (code[3*i +: 3] == col) n = n + 3'd1;
    return n;
  endfunction

  // {black, white} of code a scored against code b
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] blk, tot, ca, cb;
    blk = '0;
    tot = '0;
    for (int i = 0; i < 4; i++)
      if (a[3*i +: 3] == b[3*i +: 3]) blk = blk + 3'd1;
    for (int c = 0; c < 8; c++) begin
      ca  = count_col(a, 3'(c));
      cb  = count_col(b, 3'(c));
      tot = tot + ((ca < cb) ? ca : cb);
    end
    return {blk, 3'(tot - blk)};
  endfunction

  // {wrapped, code+1}; wrapped=1 means code was the last in enumeration
  function automatic logic [12:0] next_code(input logic [11:0] code);
    logic [11:0] n;
    logic        carry;
    n     = code;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (n[3*i +: 3] == 3'(NUM_COLORS - 1)) begin
          n[3*i +: 3] = 3'd0;
        end else begin
          n[3*i +: 3] = n[3*i +: 3] + 3'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, n};
  endfunction

  assign w_score      = score(r_cand, r_hist[r_hist_idx].g);
  assign w_match      = (w_score == {r_hist[r_hist_idx].b, r_hist[r_hist_idx].w});
  assign w_last_idx   = (LW'(r_hist_idx) == r_hist_len - LW'(1));
  assign w_cand_next  = next_code(r_cand);
  assign w_guess_next = next_code(guess);
  assign w_fb_sum     = {1'b0, fb_black} + {1'b0, fb_white};

  // Solver FSM with registered outputs
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_hist_len  <= '0;
      r_hist_idx  <= '0;
      guess       <= '0;
      guess_valid <= 1'b0;
      busy        <= 1'b0;
      solved      <= 1'b0;
      failed      <= 1'b0;
      guess_count <= '0;
`ifdef MASTERMIND_SOLVER_STATS_EN
      checks      <= '0;
`endif
      for (int i = 0; i < MAX_GUESSES; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        IDLE, DONE_WIN, DONE_FAIL: begin
          if (start) begin
            r_state     <= SEARCH;
            r_cand      <= '0;
            r_hist_len  <= '0;
            r_hist_idx  <= '0;
            busy        <= 1'b1;
            solved      <= 1'b0;
            failed      <= 1'b0;
            guess_count <= '0;
`ifdef MASTERMIND_SOLVER_STATS_EN
            checks      <= '0;
`endif
          end
        end
        SEARCH: begin
`ifdef MASTERMIND_SOLVER_STATS_EN
          // Only cycles that compare against a stored entry count as checks
          if (r_hist_len != '0 && checks != 16'hFFFF) checks <= checks + 16'd1;
`endif
          if (r_hist_len == '0 || (w_match && w_last_idx)) begin
            guess       <= r_cand;
            guess_valid <= 1'b1;
            r_state     <= PRESENT;
          end else if (w_match) begin
            r_hist_idx  <= r_hist_idx + IW'(1);
          end else if (w_cand_next[12]) begin
            r_state     <= DONE_FAIL;
            busy        <= 1'b0;
            failed      <= 1'b1;
          end else begin
            r_cand      <= w_cand_next[11:0];
            r_hist_idx  <= '0;
          end
        end
        PRESENT: begin
          if (fb_valid) begin
            guess_valid <= 1'b0;
            if (w_fb_sum > 4'd4 || (fb_black == 3'd3 && fb_white == 3'd1)) begin
              r_state <= DONE_FAIL;
              busy    <= 1'b0;
              failed  <= 1'b1;
            end else if (fb_black == 3'd4) begin
              guess_count <= guess_count + 4'd1;
              r_state     <= DONE_WIN;
              busy        <= 1'b0;
              solved      <= 1'b1;
            end else begin
              r_hist[r_hist_len[IW-1:0]] <= '{g: guess, b: fb_black, w: fb_white};
              r_hist_len  <= r_hist_len + LW'(1);
              guess_count <= guess_count + 4'd1;
              // History full, or nothing left after the current guess
              if (r_hist_len + LW'(1) == LW'(MAX_GUESSES) || w_guess_next[12]) begin
                r_state <= DONE_FAIL;
                busy    <= 1'b0;
                failed  <= 1'b1;
              end else begin
                r_cand     <= w_guess_next[11:0];
                r_hist_idx <= '0;
                r_state    <= SEARCH;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_solver.sv
// tb_mastermind_solver: the bench plays the scorer side of the guess/feedback
// handshake. Table of whole games plus hand-written protocol sequences.
module tb_mastermind_solver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] guess;
  logic        guess_valid;
  logic        fb_valid;
  logic [2:0]  fb_black;
  logic [2:0]  fb_white;
  logic        busy;
  logic        solved;
  logic        failed;
  logic [3:0]  guess_count;
`ifdef MASTERMIND_SOLVER_STATS_EN
  logic [15:0] checks;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  mastermind_solver #(.NUM_COLORS(6), .MAX_GUESSES(10)) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .start(start),
    .guess(guess),
    .guess_valid(guess_valid),
    .fb_valid(fb_valid),
    .fb_black(fb_black),
    .fb_white(fb_white),
    .busy(busy),
    .solved(solved),
    .failed(failed),
`ifdef MASTERMIND_SOLVER_STATS_EN
    .checks(checks),
`endif
    .guess_count(guess_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Peg scoring by position marking
  function automatic logic [5:0] bench_score(input logic [11:0] g, input logic [11:0] s);
    logic [2:0] gd[4];
    logic [2:0] sd[4];
    bit gu[4];
    bit su[4];
    bit found;
    int b, w;
    b = 0; w = 0;
    for (int i = 0; i < 4; i++) begin
      gd[i] = g[3*i +: 3];
      sd[i] = s[3*i +: 3];
      gu[i] = (gd[i] == sd[i]);
      su[i] = gu[i];
      if (gu[i]) b++;
    end
    for (int i = 0; i < 4; i++) begin
      if (!gu[i]) begin
        found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!found && !su[j] && gd[i] == sd[j]) begin
            su[j] = 1'b1;
            found = 1'b1;
            w++;
          end
        end
      end
    end
    return {3'(b), 3'(w)};
  endfunction

  task automatic send_fb(input logic [2:0] b, input logic [2:0] w);
    fb_valid = 1'b1; fb_black = b; fb_white = w;
    @(negedge clk);
    fb_valid = 1'b0; fb_black = '0; fb_white = '0;
  endtask

  task automatic wait_gv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (guess_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Start pulse plus the fixed two-edge latency to the first guess 0000
  task automatic start_game(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_gv_edge1"}, 32'(guess_valid), 32'd0);
    chk({tag, "_busy_edge1"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_gv_edge2"}, 32'(guess_valid), 32'd1);
    chk({tag, "_first_guess"}, 32'(guess), 32'h000);
`ifdef MASTERMIND_SOLVER_STATS_EN
    chk({tag, "_checks_first"}, 32'(checks), 32'd0);
`endif
  endtask

  typedef struct {
    logic [11:0] secret;
    bit          zero_fb;     // answer 0/0 to everything instead of scoring
    bit          exp_solved;
    logic [11:0] exp_guess;
    logic [3:0]  exp_count;
  } game_t;

  task automatic play(input game_t gm, input int k);
    logic [11:0] bg[16];
    logic [5:0]  bs[16];
    logic [11:0] zseq[6];
    logic [5:0]  fb;
    int nh;
    bit done, cons;
    string tag;
`ifdef MASTERMIND_SOLVER_STATS_EN
    logic [15:0] last_checks;
`endif
    zseq = '{12'h000, 12'h249, 12'h492, 12'h6DB, 12'h924, 12'hB6D};
    tag  = $sformatf("game%0d", k);
    nh   = 0;
    done = 1'b0;
    start_game(tag);
`ifdef MASTERMIND_SOLVER_STATS_EN
    last_checks = '0;
`endif
    for (int t = 0; t < 40000 && !done; t++) begin
      if (solved || failed) begin
        done = 1'b1;
      end else if (guess_valid) begin
        cons = 1'b1;
        for (int j = 0; j < nh; j++)
          if (bench_score(guess, bg[j]) != bs[j]) cons = 1'b0;
        chk({tag, "_consistent"}, 32'(cons), 32'd1);
        if (gm.zero_fb && nh < 6) chk({tag, "_order"}, 32'(guess), 32'(zseq[nh]));
`ifdef MASTERMIND_SOLVER_STATS_EN
        chk({tag, "_checks_mono"}, 32'(checks >= last_checks), 32'd1);
        last_checks = checks;
`endif
        fb = gm.zero_fb ? 6'd0 : bench_score(guess, gm.secret);
        if (nh < 16) begin
          bg[nh] = guess;
          bs[nh] = fb;
          nh++;
        end
        send_fb(fb[5:3], fb[2:0]);
        chk({tag, "_gv_drop"}, 32'(guess_valid), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_solved"}, 32'(solved), 32'(gm.exp_solved));
    chk({tag, "_failed"}, 32'(failed), 32'(!gm.exp_solved));
    chk({tag, "_final_guess"}, 32'(guess), 32'(gm.exp_guess));
    chk({tag, "_count"}, 32'(guess_count), 32'(gm.exp_count));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk({tag, "_no_more_gv"}, 32'(guess_valid), 32'd0);
  endtask

  game_t games[5];

  initial begin
    bit ok;
    games[0] = '{secret: 12'h000, zero_fb: 1'b0, exp_solved: 1'b1, exp_guess: 12'h000, exp_count: 4'd1};
    games[1] = '{secret: 12'h24A, zero_fb: 1'b0, exp_solved: 1'b1, exp_guess: 12'h24A, exp_count: 4'd3};
    games[2] = '{secret: 12'h001, zero_fb: 1'b0, exp_solved: 1'b1, exp_guess: 12'h001, exp_count: 4'd2};
    games[3] = '{secret: 12'hB6D, zero_fb: 1'b0, exp_solved: 1'b1, exp_guess: 12'hB6D, exp_count: 4'd6};
    games[4] = '{secret: 12'h000, zero_fb: 1'b1, exp_solved: 1'b0, exp_guess: 12'hB6D, exp_count: 4'd6};

    reset = 1'b1; start = 1'b1; fb_valid = 1'b0; fb_black = '0; fb_white = '0;
    repeat (3) @(negedge clk);
    chk("rst_guess", 32'(guess), 32'd0);
    chk("rst_gv", 32'(guess_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_solved", 32'(solved), 32'd0);
    chk("rst_failed", 32'(failed), 32'd0);
    chk("rst_count", 32'(guess_count), 32'd0);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_gv", 32'(guess_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 5; k++) play(games[k], k);

    // Illegal feedback on the first guess
    start_game("illegal");
    send_fb(3'd3, 3'd2);
    chk("illegal_failed", 32'(failed), 32'd1);
    chk("illegal_count", 32'(guess_count), 32'd0);
    chk("illegal_gv", 32'(guess_valid), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd0);

    // Illegal 3 black / 1 white
    start_game("illegal31");
    send_fb(3'd3, 3'd1);
    chk("illegal31_failed", 32'(failed), 32'd1);
    chk("illegal31_count", 32'(guess_count), 32'd0);

    // Protocol robustness
    start_game("robust");
    send_fb(3'd0, 3'd0);
    chk("robust_in_search", 32'({busy, guess_valid}), 32'b10);
    fb_valid = 1'b1; fb_black = 3'd4; fb_white = 3'd0;
    @(negedge clk);
    fb_valid = 1'b0; fb_black = '0; fb_white = '0;
    wait_gv(ok);
    chk("robust_gv_seen", 32'(ok), 32'd1);
    chk("robust_guess2", 32'(guess), 32'h249);
    chk("robust_count", 32'(guess_count), 32'd1);
    chk("robust_not_solved", 32'(solved), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_present_guess", 32'(guess), 32'h249);
    chk("start_in_present_gv", 32'(guess_valid), 32'd1);
    chk("start_in_present_count", 32'(guess_count), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_gv", 32'(guess_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_guess", 32'(guess), 32'd0);
    chk("midreset_count", 32'(guess_count), 32'd0);
    repeat (3) @(negedge clk);
    chk("midreset_idle", 32'(guess_valid), 32'd0);

    // Fresh game after the abort still starts from 0000 with empty history
    play(games[1], 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
